riscv_pmacfg_regs: RTL and testbench

- Programmable PMA configuration store. It writes the `pma_cfg`/`pma_adr` arrays that the PMA checkers in the instruction and data memory paths read.
- Software (debug/CSR bridge) programs a shadow bank over a simple register bus.
- A commit transfers the shadow bank atomically to the active bank, but only once the core reports no memory access in flight, so checkers never see a half-updated map.
- An optional sticky lock freezes the map until reset.

---
 rtl/riscv_pmacfg_regs_if.sv | 24 ++
 rtl/riscv_pmacfg_regs.sv | 188 ++++++++++++++++++
 tb/tb_riscv_pmacfg_regs.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pmacfg_regs_if.sv
// Register bus between the debug/CSR bridge (master) and the PMA config store (slave).
// The master holds req_i until it sees ack_o. The slave reports q_o and err_o
// together with ack_o.
interface riscv_pmacfg_regs_if #(
  parameter int XLEN = 32
);
  logic            req_i;
  logic            we_i;
  logic [5:0]      adr_i;
  logic [XLEN-1:0] d_i;
  logic [XLEN-1:0] q_o;
  logic            ack_o;
  logic            err_o;

  modport master (
    output req_i, we_i, adr_i, d_i,
    input  q_o, ack_o, err_o
  );

  modport slave (
    input  req_i, we_i, adr_i, d_i,
    output q_o, ack_o, err_o
  );
endinterface

// File: rtl/riscv_pmacfg_regs.sv
// PMA configuration store.
// Software programs a shadow bank over the register bus. A commit copies the
// whole shadow bank into the active bank in a single edge, once the core
// reports that no memory access is in flight. An optional sticky lock
// freezes the map until reset.
// Word map:
//   0..PMA_CNT-1       shadow cfg (14 bits, zero-extended)
//   16..16+PMA_CNT-1   shadow adr
//   32                 CTRL: bit0 commit (W1), bit1 lock (W1, sticky), bit2 pending (RO)
// cfg layout: [1:0] mem_type, [3:2] amo_type, [4] r, [5] w, [6] x, [7] c,
//             [8] cc, [9] ri, [10] wi, [11] m, [13:12] a
module riscv_pmacfg_regs #(
  parameter int              XLEN         = 32,
  parameter int              PMA_CNT      = 16,
  parameter logic [13:0]     PMA_CFG0_RST = 14'h1CF3,
  parameter logic [XLEN-1:0] PMA_ADR0_RST = {XLEN{1'b1}}
) (
  input  logic                          rst_ni,
  input  logic                          clk_i,
  riscv_pmacfg_regs_if.slave            bus,
  input  logic                          idle_i,
  output logic [PMA_CNT-1:0][13:0]      pma_cfg_o,
  output logic [PMA_CNT-1:0][XLEN-1:0]  pma_adr_o,
  output logic                          commit_pending_o,
  output logic                          locked_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Shadow bank (software view) and active bank (checker view)
  logic [13:0]     r_shd_cfg [PMA_CNT];
  logic [XLEN-1:0] r_shd_adr [PMA_CNT];
  logic [13:0]     r_act_cfg [PMA_CNT];
  logic [XLEN-1:0] r_act_adr [PMA_CNT];

  state_t          r_state;
  state_t          w_state_next;
  logic            w_apply;

  logic            r_locked;
  logic            r_ack;
  logic            r_err;
  logic [XLEN-1:0] r_q;

  logic            w_acc;
  logic            w_in_range;
  logic            w_sel_cfg;
  logic            w_sel_adr;
  logic            w_sel_ctrl;
  logic            w_mapped;
  logic            w_err;
  logic            w_wr;
  logic            w_commit_req;
  logic            w_lock_req;
  logic [3:0]      w_idx;
  logic [XLEN-1:0] w_rdata;

  // A request arriving while ack is still high is ignored; the master re-presents it.
  assign w_acc      = bus.req_i & ~r_ack;

  assign w_idx      = bus.adr_i[3:0];
  assign w_in_range = ({1'b0, w_idx} < 5'(PMA_CNT));
  assign w_sel_cfg  = (bus.adr_i[5:4] == 2'b00) & w_in_range;
  assign w_sel_adr  = (bus.adr_i[5:4] == 2'b01) & w_in_range;
  assign w_sel_ctrl = (bus.adr_i == 6'd32);
  assign w_mapped   = w_sel_cfg | w_sel_adr | w_sel_ctrl;

  // Unmapped indices always fail; once locked, every write to a mapped index fails.
  assign w_err      = ~w_mapped | (bus.we_i & r_locked);
  assign w_wr       = w_acc & bus.we_i & w_mapped & ~r_locked;

  assign w_commit_req = w_wr & w_sel_ctrl & bus.d_i[0];
  assign w_lock_req   = w_wr & w_sel_ctrl & bus.d_i[1];

  // Read mux: returns shadow contents, or the CTRL status word.
  always_comb begin
    w_rdata = '0;
    if (w_sel_cfg) begin
      w_rdata = XLEN'(r_shd_cfg[w_idx]);
    end else if (w_sel_adr) begin
      w_rdata = r_shd_adr[w_idx];
    end else if (w_sel_ctrl) begin
      w_rdata = XLEN'({r_state == ST_PENDING, r_locked, 1'b0});
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Commit FSM next state. idle_i is ignored in IDLE, so a commit requested
  // while the core is already idle still waits one cycle before applying.
  always_comb begin
    w_state_next = r_state;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit_req) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (idle_i) begin
          w_apply      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shadow bank: updated by bus writes. Writes are still allowed while a commit is pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PMA_CNT; i++) begin
        r_shd_cfg[i] <= (i == 0) ? PMA_CFG0_RST : 14'h0;
        r_shd_adr[i] <= (i == 0) ? PMA_ADR0_RST : '0;
      end
    end else begin
      for (int i = 0; i < PMA_CNT; i++) begin
        if (w_wr && w_sel_cfg && (w_idx == 4'(i))) begin
          r_shd_cfg[i] <= bus.d_i[13:0];
        end
        if (w_wr && w_sel_adr && (w_idx == 4'(i))) begin
          r_shd_adr[i] <= bus.d_i;
        end
      end
    end
  end

  // Active bank: every entry is copied on the same apply edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PMA_CNT; i++) begin
        r_act_cfg[i] <= (i == 0) ? PMA_CFG0_RST : 14'h0;
        r_act_adr[i] <= (i == 0) ? PMA_ADR0_RST : '0;
      end
    end else if (w_apply) begin
      for (int i = 0; i < PMA_CNT; i++) begin
        r_act_cfg[i] <= r_shd_cfg[i];
        r_act_adr[i] <= r_shd_adr[i];
      end
    end
  end

  // Sticky lock. It never cancels a commit that is already pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked <= 1'b0;
    end else if (w_lock_req) begin
      r_locked <= 1'b1;
    end
  end

  // Bus response: one-cycle pulse of ack, with err and q registered alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_q   <= '0;
    end else begin
      r_ack <= w_acc;
      r_err <= w_acc & w_err;
      r_q   <= (w_acc && !w_err && !bus.we_i) ? w_rdata : '0;
    end
  end

  assign bus.ack_o        = r_ack;
  assign bus.err_o        = r_err;
  assign bus.q_o          = r_q;
  assign commit_pending_o = (r_state == ST_PENDING);
  assign locked_o         = r_locked;

  // Checker-facing outputs come straight from the active flops.
  for (genvar gi = 0; gi < PMA_CNT; gi++) begin : g_out
    assign pma_cfg_o[gi] = r_act_cfg[gi];
    assign pma_adr_o[gi] = r_act_adr[gi];
  end

endmodule

// File: tb/tb_riscv_pmacfg_regs.sv
// Randomized bench for riscv_pmacfg_regs. A behavioural model holds both banks
// and the pending/lock flags as plain arrays and bits. It is stepped once per
// clock edge and compared against every DUT output after every edge.
`timescale 1ns/1ps
module tb_riscv_pmacfg_regs;
  localparam int XLEN    = 32;
  localparam int PMA_CNT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic idle  = 1'b0;

  logic [PMA_CNT-1:0][13:0]     pma_cfg;
  logic [PMA_CNT-1:0][XLEN-1:0] pma_adr;
  logic                         pend;
  logic                         locked;

  always #5 clk = ~clk;

  riscv_pmacfg_regs_if #(.XLEN(XLEN)) bus ();

  riscv_pmacfg_regs #(.XLEN(XLEN), .PMA_CNT(PMA_CNT)) dut (
    .rst_ni           (rst_n),
    .clk_i            (clk),
    .bus              (bus),
    .idle_i           (idle),
    .pma_cfg_o        (pma_cfg),
    .pma_adr_o        (pma_adr),
    .commit_pending_o (pend),
    .locked_o         (locked)
  );

  // Reference model state
  logic [13:0] m_shd_cfg [PMA_CNT];
  logic [31:0] m_shd_adr [PMA_CNT];
  logic [13:0] m_act_cfg [PMA_CNT];
  logic [31:0] m_act_adr [PMA_CNT];
  bit          m_pending, m_locked, m_ack, m_err;
  logic [31:0] m_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < PMA_CNT; i++) begin
      m_shd_cfg[i] = (i == 0) ? 14'h1CF3 : 14'h0;
      m_act_cfg[i] = (i == 0) ? 14'h1CF3 : 14'h0;
      m_shd_adr[i] = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
      m_act_adr[i] = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
    end
    m_pending = 1'b0;
    m_locked  = 1'b0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_q       = 32'h0;
  endfunction

  task automatic check_outputs();
    logic [PMA_CNT-1:0][13:0]     exp_cfg;
    logic [PMA_CNT-1:0][XLEN-1:0] exp_adr;
    for (int i = 0; i < PMA_CNT; i++) begin
      exp_cfg[i] = m_act_cfg[i];
      exp_adr[i] = m_act_adr[i];
    end
    check_val("ack", 512'(bus.ack_o), 512'(m_ack));
    if (m_ack) begin
      check_val("err", 512'(bus.err_o), 512'(m_err));
      check_val("q", 512'(bus.q_o), 512'(m_q));
    end
    check_val("pending", 512'(pend), 512'(m_pending));
    check_val("locked", 512'(locked), 512'(m_locked));
    check_val("act_cfg", 512'(pma_cfg), 512'(exp_cfg));
    check_val("act_adr", 512'(pma_adr), 512'(exp_adr));
  endtask

  // Steps the model for the coming edge, then waits for the edge and compares.
  task automatic tick();
    bit   acc, pend0, lock0, we;
    int   a;
    logic [31:0] d;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc   = bus.req_i && !m_ack;
      we    = bus.we_i;
      a     = int'(bus.adr_i);
      d     = bus.d_i;
      pend0 = m_pending;
      lock0 = m_locked;
      // The apply edge copies the shadow as it stood before this edge.
      if (pend0 && idle) begin
        for (int i = 0; i < PMA_CNT; i++) begin
          m_act_cfg[i] = m_shd_cfg[i];
          m_act_adr[i] = m_shd_adr[i];
        end
        m_pending = 1'b0;
      end
      m_err = 1'b0;
      m_q   = 32'h0;
      if (acc) begin
        if (a < PMA_CNT) begin
          if (!we) m_q = {18'h0, m_shd_cfg[a]};
          else if (lock0) m_err = 1'b1;
          else m_shd_cfg[a] = d[13:0];
        end else if (a >= 16 && a < 16 + PMA_CNT) begin
          if (!we) m_q = m_shd_adr[a - 16];
          else if (lock0) m_err = 1'b1;
          else m_shd_adr[a - 16] = d;
        end else if (a == 32) begin
          if (!we) m_q = {29'h0, pend0, lock0, 1'b0};
          else if (lock0) m_err = 1'b1;
          else begin
            if (d[0] && !pend0) m_pending = 1'b1;
            if (d[1]) m_locked = 1'b1;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      m_ack = acc;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // One bus access. With hold set, req stays high through the ack cycle, so
  // the DUT must ignore that second sighting of the request.
  task automatic xfer(input bit we, input int adr, input logic [31:0] d, input bit hold);
    bus.req_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = 6'(adr);
    bus.d_i   = d;
    tick();
    if (hold) tick();
    bus.req_i = 1'b0;
    tick();
    $display("xfer we=%0d adr=%0d d=%08h -> q=%08h err=%0d pend=%0d lock=%0d",
             we, adr, d, m_q, m_err, m_pending, m_locked);
  endtask

  initial begin
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 6'd0;
    bus.d_i   = 32'h0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_outputs();
    check_val("rst_cfg0", 512'(pma_cfg[0]), 512'(14'h1CF3));
    check_val("rst_adr0", 512'(pma_adr[0]), 512'(32'hFFFF_FFFF));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Shadow write/read of idx 17; active bank is untouched
    xfer(1'b1, 17, 32'h2000_03FF, 1'b0);
    xfer(1'b0, 17, 32'h0, 1'b0);
    check_val("adr1_before_commit", 512'(pma_adr[1]), 512'(32'h0));

    // Commit held off by idle_i=0 for five cycles
    idle = 1'b0;
    xfer(1'b1, 32, 32'h1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check_val("pending_held", 512'(pend), 512'(1'b1));
    idle = 1'b1;
    tick();
    check_val("adr1_committed", 512'(pma_adr[1]), 512'(32'h2000_03FF));
    check_val("pending_cleared", 512'(pend), 512'(1'b0));

    // Shadow written while pending is what gets applied
    idle = 1'b0;
    xfer(1'b1, 32, 32'h1, 1'b0);
    xfer(1'b1, 1, 32'h0000_1055, 1'b0);
    idle = 1'b1;
    tick();
    check_val("cfg1_apply_time", 512'(pma_cfg[1]), 512'(14'h1055));

    // Randomized traffic, never setting the lock bit
    for (int k = 0; k < 250; k++) begin
      int a;
      logic [31:0] d;
      idle = ($urandom_range(0, 2) == 0);
      a = int'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) a = 32;
      d = $urandom;
      if (a == 32) d[1] = 1'b0;
      xfer(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        idle = 1'($urandom_range(0, 1));
        tick();
      end
    end

    // Reset in the middle of a pending commit
    idle = 1'b0;
    xfer(1'b1, 18, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32, 32'h1, 1'b0);
    check_val("pending_before_rst", 512'(pend), 512'(1'b1));
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    tick();
    rst_n = 1'b1;
    idle = 1'b1;
    tick();
    tick();

    // Combined commit+lock while idle; then writes are refused, reads allowed
    xfer(1'b1, 2, 32'h0000_0ABC, 1'b0);
    xfer(1'b1, 18, 32'h1234_5678, 1'b0);
    xfer(1'b1, 32, 32'h3, 1'b0);
    check_val("locked_set", 512'(locked), 512'(1'b1));
    check_val("cfg2_locked_commit", 512'(pma_cfg[2]), 512'(14'h0ABC));
    xfer(1'b1, 0, 32'h0, 1'b0);
    xfer(1'b0, 0, 32'h0, 1'b0);
    xfer(1'b1, 32, 32'h1, 1'b0);
    xfer(1'b1, 17, 32'h5555_5555, 1'b1);
    xfer(1'b0, 32, 32'h0, 1'b0);

    // Unmapped read
    xfer(1'b0, 40, 32'h0, 1'b0);
    xfer(1'b0, 63, 32'h0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
